lock_sequencer: RTL and testbench

//   Sequences the combination-lock match datapath on the DE10-Lite. Takes the raw ENTER key
//   and the switch value, and checks entered digits against a stored code one digit per press.

---
 rtl/lock_sequencer.sv | 178 +++++++++++++++++
 tb/tb_lock_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - combination lock entry sequencer with timed unlock/error/lockout
module lock_sequencer #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter int OPEN_CYCLES    = 50000000,
  parameter int ERR_CYCLES     = 25000000,
  parameter int LOCKOUT_CYCLES = 250000000,
  parameter int MAX_FAILS      = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enter_n,
  input  logic [DIGIT_W-1:0]                  sw_code,
  input  logic [N_DIGITS*DIGIT_W-1:0]         code_flat,
  output logic                                unlock,
  output logic                                error,
  output logic                                lockout,
  output logic [$clog2(N_DIGITS)-1:0]         digit_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);

  // One timer serves all three timed states, so it is sized for the longest one.
  localparam int MAX_OE  = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
  localparam int MAX_CYC = (MAX_OE > LOCKOUT_CYCLES) ? MAX_OE : LOCKOUT_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] ERR_LOAD  = TMR_W'(ERR_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  MAX_FC    = FC_W'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t             state_q;
  logic               s1_q, s2_q, s3_q;
  logic               press_q;
  logic               press_d;
  logic               mismatch_q;
  logic [IDX_W-1:0]   digit_idx_q;
  logic [FC_W-1:0]    fail_count_q;
  logic [TMR_W-1:0]   timer_q;
  logic               unlock_q, error_q, lockout_q;

  logic [DIGIT_W-1:0] exp_digit;
  logic               digit_miss;
  logic [FC_W-1:0]    fail_inc;

  // Falling-edge detect on the synchronized key; one pulse per high->low transition.
  always_comb begin
    press_d = s3_q & ~s2_q;
  end

  // Two-flop synchronizer plus history flop; idle (released key) value is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      press_q <= 1'b0;
    end else begin
      s1_q    <= enter_n;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      press_q <= press_d;
    end
  end

  // Select the stored digit for the current position and compare with the switches.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        exp_digit = code_flat[i*DIGIT_W +: DIGIT_W];
      end
    end
    digit_miss = (sw_code != exp_digit);
    fail_inc   = (fail_count_q == MAX_FC) ? MAX_FC : (fail_count_q + FC_W'(1));
  end

  // Main sequencer: digit entry, timed result states and failed-attempt bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      mismatch_q   <= 1'b0;
      digit_idx_q  <= '0;
      fail_count_q <= '0;
      timer_q      <= '0;
      unlock_q     <= 1'b0;
      error_q      <= 1'b0;
      lockout_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (press_q) begin
            if (digit_idx_q != LAST_IDX) begin
              digit_idx_q <= digit_idx_q + IDX_W'(1);
              if (digit_miss) begin
                mismatch_q <= 1'b1;
              end
            end else begin
              // Last digit: the verdict covers every digit, never which one was wrong.
              digit_idx_q <= '0;
              mismatch_q  <= 1'b0;
              if (mismatch_q || digit_miss) begin
                state_q      <= ST_FAIL;
                error_q      <= 1'b1;
                timer_q      <= ERR_LOAD;
                fail_count_q <= fail_inc;
              end else begin
                state_q      <= ST_OPEN;
                unlock_q     <= 1'b1;
                timer_q      <= OPEN_LOAD;
                fail_count_q <= '0;
              end
            end
          end
        end

        ST_OPEN: begin
          if (timer_q == '0) begin
            state_q  <= ST_ENTRY;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end

        ST_FAIL: begin
          if (timer_q == '0) begin
            error_q <= 1'b0;
            if (fail_count_q == MAX_FC) begin
              state_q   <= ST_LOCKOUT;
              lockout_q <= 1'b1;
              timer_q   <= LOCK_LOAD;
            end else begin
              state_q <= ST_ENTRY;
            end
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end

        ST_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q      <= ST_ENTRY;
            lockout_q    <= 1'b0;
            fail_count_q <= '0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end

        default: begin
          state_q   <= ST_ENTRY;
          unlock_q  <= 1'b0;
          error_q   <= 1'b0;
          lockout_q <= 1'b0;
        end
      endcase
    end
  end

  assign unlock     = unlock_q;
  assign error      = error_q;
  assign lockout    = lockout_q;
  assign digit_idx  = digit_idx_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - scoreboard bench for lock_sequencer with a per-press reference model
module tb_lock_sequencer;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int OPEN  = 8;
  localparam int ERR   = 4;
  localparam int LOCK  = 16;
  localparam int MAXF  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enter_n = 1'b1;
  logic [DW-1:0] sw_code = '0;
  logic [15:0]   code_flat = 16'hC5A3;
  logic          unlock, error, lockout;
  logic [1:0]    digit_idx;
  logic [1:0]    fail_count;

  lock_sequencer #(
    .N_DIGITS(ND), .DIGIT_W(DW), .OPEN_CYCLES(OPEN), .ERR_CYCLES(ERR),
    .LOCKOUT_CYCLES(LOCK), .MAX_FAILS(MAXF)
  ) dut (
    .clk(clk), .reset(reset), .enter_n(enter_n), .sw_code(sw_code),
    .code_flat(code_flat), .unlock(unlock), .error(error), .lockout(lockout),
    .digit_idx(digit_idx), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Expected output pulses: kind 0=unlock 1=error 2=lockout
  typedef struct {
    int kind;
    int start;
    int len;
    int fc;
  } ev_t;
  ev_t sb[$];

  // Reference model state: position in the code, accumulated mismatch,
  // consecutive failures, and the first clock edge at which a press is accepted again.
  int m_idx = 0;
  bit m_mis = 0;
  int m_fails = 0;
  int free_at = 0;

  // Monitor: measures each output pulse and compares against the scoreboard
  bit act_k [3];
  int st_k  [3];
  int ln_k  [3];
  int fc_k  [3];

  always @(negedge clk) begin
    logic [2:0] o;
    ev_t e;
    o = {lockout, error, unlock};
    if (reset) begin
      for (int k = 0; k < 3; k++) act_k[k] = 0;
    end else begin
      check("mutex", int'($countones(o) <= 1), 1);
      for (int k = 0; k < 3; k++) begin
        if (o[k]) begin
          if (!act_k[k]) begin
            act_k[k] = 1;
            st_k[k] = cyc;
            ln_k[k] = 1;
            fc_k[k] = int'(fail_count);
          end else begin
            ln_k[k]++;
          end
        end else if (act_k[k]) begin
          act_k[k] = 0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse kind=%0d start=%0d len=%0d required=none", k, st_k[k], ln_k[k]);
          end else begin
            e = sb.pop_front();
            check("pulse_kind", k, e.kind);
            check("pulse_start", st_k[k], e.start);
            check("pulse_len", ln_k[k], e.len);
            check("pulse_fail_count", fc_k[k], e.fc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One key press; the model decides acceptance from the edge where the FSM will act.
  task automatic press(input logic [3:0] d, input int hold, input int gap);
    int e_edge;
    logic [3:0] ref_d;
    sw_code = d;
    enter_n = 1'b0;
    e_edge = cyc + 4;
    if (e_edge >= free_at) begin
      ref_d = code_flat[m_idx*DW +: DW];
      if (d != ref_d) m_mis = 1;
      if (m_idx == ND - 1) begin
        if (m_mis) begin
          if (m_fails < MAXF) m_fails++;
          sb.push_back('{1, e_edge, ERR, m_fails});
          if (m_fails == MAXF) begin
            sb.push_back('{2, e_edge + ERR, LOCK, MAXF});
            free_at = e_edge + ERR + LOCK + 1;
            m_fails = 0;
          end else begin
            free_at = e_edge + ERR + 1;
          end
        end else begin
          sb.push_back('{0, e_edge, OPEN, 0});
          m_fails = 0;
          free_at = e_edge + OPEN + 1;
        end
        m_idx = 0;
        m_mis = 0;
      end else begin
        m_idx++;
      end
    end
    repeat (hold) step();
    enter_n = 1'b1;
    repeat (gap) step();
    check("digit_idx", int'(digit_idx), m_idx);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < ND; i++) press(c[i*DW +: DW], $urandom_range(1, 3), $urandom_range(3, 5));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!unlock && !error && !lockout && sb.size() == 0) begin
        step();
        step();
        return;
      end
      step();
    end
    bound_fail("wait_idle");
  endtask

  task automatic wait_high(input int k);
    for (int i = 0; i < 300; i++) begin
      if ((k == 0 && unlock) || (k == 1 && error) || (k == 2 && lockout)) return;
      step();
    end
    bound_fail("wait_high");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    m_idx = 0;
    m_mis = 0;
    m_fails = 0;
    free_at = 0;
    step();
    reset = 1'b0;
    check("rst_unlock", int'(unlock), 0);
    check("rst_error", int'(error), 0);
    check("rst_lockout", int'(lockout), 0);
    check("rst_digit_idx", int'(digit_idx), 0);
    check("rst_fail_count", int'(fail_count), 0);
  endtask

  task automatic check_idle_state();
    check("idle_digit_idx", int'(digit_idx), m_idx);
    check("idle_fail_count", int'(fail_count), m_fails);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] good, bad, rc;
    good = 16'hC5A3;
    bad  = 16'hC5B3;
    repeat (3) step();
    do_reset();

    // correct code unlocks
    enter_code(good);
    wait_idle();
    check_idle_state();

    // one wrong digit in position 1
    enter_code(bad);
    wait_idle();
    check_idle_state();

    // two more wrong codes lead to lockout; presses during lockout are ignored
    enter_code(bad);
    wait_idle();
    enter_code(bad);
    wait_high(2);
    press(4'h3, 1, 3);
    press(4'hA, 2, 3);
    wait_idle();
    check_idle_state();
    enter_code(good);
    wait_idle();
    check_idle_state();

    // key held low for 100 cycles counts once
    press(4'h3, 100, 3);
    press(4'hA, 1, 3);
    press(4'h5, 1, 3);
    press(4'hC, 1, 3);
    wait_idle();
    check_idle_state();

    // press while open is discarded, entry restarts at digit 0
    enter_code(good);
    wait_high(0);
    press(4'h3, 1, 3);
    wait_idle();
    enter_code(good);
    wait_idle();
    check_idle_state();

    // reset after two digits, then mid-lockout
    press(4'h3, 1, 3);
    press(4'hA, 1, 3);
    do_reset();
    enter_code(good);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      enter_code(bad);
      if (i < 2) wait_idle();
    end
    wait_high(2);
    repeat (5) step();
    do_reset();
    enter_code(good);
    wait_idle();
    check_idle_state();

    // randomized entries, codes and press timing, including presses into busy states
    for (int n = 0; n < 30; n++) begin
      if (m_idx == 0 && $urandom_range(0, 3) == 0) code_flat = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rc = code_flat;
      end else begin
        rc = 16'($urandom);
      end
      for (int i = 0; i < ND; i++) press(rc[i*DW +: DW], $urandom_range(1, 4), $urandom_range(3, 6));
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        check_idle_state();
      end
    end
    wait_idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
